// File: rtl/blast_resolver_if.sv
`default_nettype none
// ============================================================================
// Module      : blast_resolver_if
// Description : Detonation request, map read port and clear/flame outputs of
//               one blast resolver. The master side is the resolver itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface blast_resolver_if;
  logic        start;
  logic [8:0]  bomb_idx;
  logic [8:0]  map_rd_idx;
  logic [2:0]  map_rd_val;
  logic [31:0] change;
  logic        flame_valid;
  logic [8:0]  flame_idx;
  logic        busy;
  logic        done;
  logic        hit3;
  logic        hit4;

  modport master (
    input  start, bomb_idx, map_rd_val,
    output map_rd_idx, change, flame_valid, flame_idx, busy, done, hit3, hit4
  );

  modport slave (
    output start, bomb_idx, map_rd_val,
    input  map_rd_idx, change, flame_valid, flame_idx, busy, done, hit3, hit4
  );
endinterface
`default_nettype wire

// File: rtl/blast_resolver.sv
`default_nettype none
// ============================================================================
// Module      : blast_resolver
// Description : Resolves one bomb detonation against the live tile map:
//               centre flame, then four rays (UP, RIGHT, DOWN, LEFT), one
//               cell per cycle, producing flame cells and clear requests.
// Revision    : 1.0 - initial release
// ============================================================================
module blast_resolver #(
  parameter int MAP_W = 20,
  parameter int MAP_H = 15,
  parameter int RANGE = 3
) (
  input  logic             clk,
  input  logic             rst,
  blast_resolver_if.master bus
);
  localparam int                CELLS     = MAP_W * MAP_H;
  localparam logic signed [10:0] COLS      = 11'(MAP_W);
  localparam logic signed [10:0] ROWS      = 11'(MAP_H);
  localparam logic [3:0]         LAST_STEP = 4'(RANGE);

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_LEFT  = 2'd3;

  typedef enum logic [1:0] {IDLE, CENTER, RAY, DONE} state_t;

  state_t             state;
  logic [8:0]         bomb;
  logic signed [10:0] row;
  logic signed [10:0] col;
  logic [1:0]         dir;
  logic [3:0]         step;

  logic               flame_v;
  logic [8:0]         flame_at;
  logic [31:0]        change_q;
  logic               busy_q;
  logic               done_q;
  logic               hit3_q;
  logic               hit4_q;

  logic signed [10:0] step_s;
  logic signed [10:0] cand_row;
  logic signed [10:0] cand_col;
  logic               off_grid;
  logic [8:0]         cand_idx;
  logic [8:0]         rd_idx;
  logic               ray_flame;
  logic               ray_change;
  logic               ray_hit3;
  logic               ray_hit4;
  logic               ray_end;

  // Candidate cell of the current ray step; rows and columns are checked
  // separately so a horizontal ray can never wrap into the adjacent row.
  always_comb begin
    step_s   = 11'(step);
    cand_row = row;
    cand_col = col;
    case (dir)
      DIR_UP:    cand_row = row - step_s;
      DIR_RIGHT: cand_col = col + step_s;
      DIR_DOWN:  cand_row = row + step_s;
      default:   cand_col = col - step_s;
    endcase
    off_grid = (cand_row < 0) || (cand_row >= ROWS) ||
               (cand_col < 0) || (cand_col >= COLS);
    cand_idx = 9'(cand_row * COLS + cand_col);
  end

  // Outcome of evaluating the candidate's tile code this cycle.
  always_comb begin
    ray_flame  = 1'b0;
    ray_change = 1'b0;
    ray_hit3   = 1'b0;
    ray_hit4   = 1'b0;
    ray_end    = 1'b1;
    if (!off_grid) begin
      case (bus.map_rd_val)
        3'd0: begin
          ray_flame = 1'b1;
          ray_end   = (step == LAST_STEP);
        end
        3'd2: begin
          ray_flame  = 1'b1;
          ray_change = 1'b1;
        end
        3'd3:    ray_hit3 = 1'b1;
        3'd4:    ray_hit4 = 1'b1;
        default: ;
      endcase
    end
  end

  // Map address: bomb cell in CENTER, on-grid candidate in RAY, else 0.
  always_comb begin
    rd_idx = '0;
    if (state == CENTER) begin
      rd_idx = bomb;
    end else if ((state == RAY) && !off_grid) begin
      rd_idx = cand_idx;
    end
  end

  // Scan sequencer with registered flame/change/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bomb     <= '0;
      row      <= '0;
      col      <= '0;
      dir      <= DIR_UP;
      step     <= 4'd1;
      flame_v  <= 1'b0;
      flame_at <= '0;
      change_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      hit3_q   <= 1'b0;
      hit4_q   <= 1'b0;
    end else begin
      flame_v  <= 1'b0;
      change_q <= '0;
      done_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && (int'(bus.bomb_idx) < CELLS)) begin
            bomb   <= bus.bomb_idx;
            row    <= 11'(int'(bus.bomb_idx) / MAP_W);
            col    <= 11'(int'(bus.bomb_idx) % MAP_W);
            busy_q <= 1'b1;
            state  <= CENTER;
          end
        end
        CENTER: begin
          flame_v  <= 1'b1;
          flame_at <= bomb;
          dir      <= DIR_UP;
          step     <= 4'd1;
          state    <= RAY;
        end
        RAY: begin
          if (ray_flame) begin
            flame_v  <= 1'b1;
            flame_at <= cand_idx;
          end
          if (ray_change) change_q <= 32'(cand_idx);
          if (ray_hit3)   hit3_q   <= 1'b1;
          if (ray_hit4)   hit4_q   <= 1'b1;
          if (ray_end) begin
            step <= 4'd1;
            dir  <= dir + 2'd1;
            if (dir == DIR_LEFT) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= DONE;
            end
          end else begin
            step <= step + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.map_rd_idx  = rd_idx;
  assign bus.change      = change_q;
  assign bus.flame_valid = flame_v;
  assign bus.flame_idx   = flame_at;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.hit3        = hit3_q;
  assign bus.hit4        = hit4_q;
endmodule
`default_nettype wire
